// File: rtl/param_tiny_processor.sv
// Parametrised accumulator processor: 16-opcode ISA, DW-bit data, 2^AW-word program RAM,
// with host program load and run/halt/single-step control.
module param_tiny_processor #(
   parameter int unsigned DW = 4,
   parameter int unsigned AW = 4
) (
   input  logic            clock,
   input  logic            reset_p,
   input  logic [DW-1:0]   gpio_in,
   output logic [DW-1:0]   gpio_out,
   input  logic            start,
   input  logic            halt_req,
   input  logic            step,
   input  logic            prog_we,
   input  logic [AW-1:0]   prog_addr,
   input  logic [DW+3:0]   prog_data,
   output logic            halted,
   output logic [AW-1:0]   pc,
   output logic            cf,
   output logic            retire
);

   typedef enum logic [2:0] {
      S_HALT, S_FETCH, S_DECODE, S_SELECT, S_EXEC, S_WB
   } state_t;

   typedef enum logic [1:0] {
      SEL_A, SEL_B, SEL_IN, SEL_ZERO
   } sel_t;

   typedef enum logic [3:0] {
      OP_MOVA_I = 4'h0, OP_MOVB_I = 4'h1, OP_MOVA_B = 4'h2, OP_MOVB_A = 4'h3,
      OP_ADDA_I = 4'h4, OP_ADDB_I = 4'h5, OP_IN_A   = 4'h6, OP_IN_B   = 4'h7,
      OP_OUT_I  = 4'h8, OP_OUT_B  = 4'h9, OP_JMP    = 4'hA, OP_JNC    = 4'hB,
      OP_NOP_C  = 4'hC, OP_NOP_D  = 4'hD, OP_NOP_E  = 4'hE, OP_HLT    = 4'hF
   } opcode_t;

   // Program RAM: deliberately outside the reset domain so a loaded program survives reset_p.
   logic [DW+3:0] ram_q [2**AW];
   logic [DW+3:0] fetch_word;

   state_t        state_q, state_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [DW-1:0] rega_q, rega_d;
   logic [DW-1:0] regb_q, regb_d;
   logic [DW-1:0] gpio_q, gpio_d;
   logic          cf_q, cf_d;
   logic          retire_q, retire_d;
   logic          run_q, run_d;
   logic          halt_pend_q, halt_pend_d;
   opcode_t       op_q, op_d;
   logic [DW-1:0] imm_q, imm_d;
   logic          wr_a_q, wr_a_d;
   logic          wr_b_q, wr_b_d;
   logic          wr_out_q, wr_out_d;
   logic          jump_q, jump_d;
   sel_t          sel_q, sel_d;
   logic [DW-1:0] sel_val_q, sel_val_d;
   logic [DW-1:0] add_q, add_d;

   assign fetch_word = ram_q[pc_q];

   always_ff @(posedge clock) begin
      if (prog_we && (state_q == S_HALT)) begin
         ram_q[prog_addr] <= prog_data;
      end
   end

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      rega_d      = rega_q;
      regb_d      = regb_q;
      gpio_d      = gpio_q;
      cf_d        = cf_q;
      retire_d    = 1'b0;
      run_d       = run_q;
      halt_pend_d = halt_pend_q;
      op_d        = op_q;
      imm_d       = imm_q;
      wr_a_d      = wr_a_q;
      wr_b_d      = wr_b_q;
      wr_out_d    = wr_out_q;
      jump_d      = jump_q;
      sel_d       = sel_q;
      sel_val_d   = sel_val_q;
      add_d       = add_q;

      if (state_q != S_HALT && halt_req) begin
         halt_pend_d = 1'b1;
      end

      case (state_q)
         S_HALT: begin
            halt_pend_d = 1'b0;
            if (start) begin
               // halt_req arriving with start cancels the start.
               if (!halt_req) begin
                  run_d   = 1'b1;
                  state_d = S_FETCH;
               end
            end else if (step) begin
               run_d   = 1'b0;
               state_d = S_FETCH;
            end
         end

         S_FETCH: begin
            op_d    = opcode_t'(fetch_word[DW+3:DW]);
            imm_d   = fetch_word[DW-1:0];
            state_d = S_DECODE;
         end

         S_DECODE: begin
            wr_a_d   = 1'b0;
            wr_b_d   = 1'b0;
            wr_out_d = 1'b0;
            jump_d   = 1'b0;
            sel_d    = SEL_ZERO;
            case (op_q)
               OP_MOVA_I: wr_a_d = 1'b1;
               OP_MOVB_I: wr_b_d = 1'b1;
               OP_MOVA_B: begin sel_d = SEL_B;  wr_a_d = 1'b1; end
               OP_MOVB_A: begin sel_d = SEL_A;  wr_b_d = 1'b1; end
               OP_ADDA_I: begin sel_d = SEL_A;  wr_a_d = 1'b1; end
               OP_ADDB_I: begin sel_d = SEL_B;  wr_b_d = 1'b1; end
               OP_IN_A:   begin sel_d = SEL_IN; wr_a_d = 1'b1; end
               OP_IN_B:   begin sel_d = SEL_IN; wr_b_d = 1'b1; end
               OP_OUT_I:  wr_out_d = 1'b1;
               OP_OUT_B:  begin sel_d = SEL_B;  wr_out_d = 1'b1; end
               OP_JMP:    jump_d = 1'b1;
               OP_JNC:    jump_d = ~cf_q;
               default:   ;
            endcase
            state_d = S_SELECT;
         end

         S_SELECT: begin
            case (sel_q)
               SEL_A:   sel_val_d = rega_q;
               SEL_B:   sel_val_d = regb_q;
               SEL_IN:  sel_val_d = gpio_in;
               default: sel_val_d = '0;
            endcase
            state_d = S_EXEC;
         end

         S_EXEC: begin
            {cf_d, add_d} = {1'b0, sel_val_q} + {1'b0, imm_q};
            state_d       = S_WB;
         end

         S_WB: begin
            if (wr_a_q)   rega_d = add_q;
            if (wr_b_q)   regb_d = add_q;
            if (wr_out_q) gpio_d = add_q;
            pc_d     = jump_q ? add_q[AW-1:0] : pc_q + AW'(1);
            retire_d = 1'b1;
            if (op_q == OP_HLT) begin
               run_d = 1'b0;
            end
            if ((op_q == OP_HLT) || !run_q || halt_pend_q || halt_req) begin
               state_d     = S_HALT;
               halt_pend_d = 1'b0;
            end else begin
               state_d = S_FETCH;
            end
         end

         default: state_d = S_HALT;
      endcase
   end

   always_ff @(posedge clock or posedge reset_p) begin
      if (reset_p) begin
         state_q     <= S_HALT;
         pc_q        <= '0;
         rega_q      <= '0;
         regb_q      <= '0;
         gpio_q      <= '0;
         cf_q        <= 1'b0;
         retire_q    <= 1'b0;
         run_q       <= 1'b0;
         halt_pend_q <= 1'b0;
         op_q        <= OP_MOVA_I;
         imm_q       <= '0;
         wr_a_q      <= 1'b0;
         wr_b_q      <= 1'b0;
         wr_out_q    <= 1'b0;
         jump_q      <= 1'b0;
         sel_q       <= SEL_ZERO;
         sel_val_q   <= '0;
         add_q       <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         rega_q      <= rega_d;
         regb_q      <= regb_d;
         gpio_q      <= gpio_d;
         cf_q        <= cf_d;
         retire_q    <= retire_d;
         run_q       <= run_d;
         halt_pend_q <= halt_pend_d;
         op_q        <= op_d;
         imm_q       <= imm_d;
         wr_a_q      <= wr_a_d;
         wr_b_q      <= wr_b_d;
         wr_out_q    <= wr_out_d;
         jump_q      <= jump_d;
         sel_q       <= sel_d;
         sel_val_q   <= sel_val_d;
         add_q       <= add_d;
      end
   end

   assign gpio_out = gpio_q;
   assign halted   = (state_q == S_HALT);
   assign pc       = pc_q;
   assign cf       = cf_q;
   assign retire   = retire_q;

endmodule

// File: tb/tb_param_tiny_processor.sv
// Directed bench: table of stepped micro-programs plus hand sequences for run/halt/reset corners,
// and a DW=8/AW=6 instance for wrap and carry boundaries.
module tb_param_tiny_processor;

   logic        clock = 1'b0;
   logic        reset_p;
   logic [3:0]  gpio_in;
   logic [3:0]  gpio_out;
   logic        start, halt_req, step, prog_we;
   logic [3:0]  prog_addr;
   logic [7:0]  prog_data;
   logic        halted, cf, retire;
   logic [3:0]  pc;

   logic [7:0]  b_gpio_in;
   logic [7:0]  b_gpio_out;
   logic        b_start, b_halt_req, b_step, b_prog_we;
   logic [5:0]  b_prog_addr;
   logic [11:0] b_prog_data;
   logic        b_halted, b_cf, b_retire;
   logic [5:0]  b_pc;

   int checks = 0;
   int failures = 0;

   always #5 clock = ~clock;

   param_tiny_processor #(.DW(4), .AW(4)) dut (
      .clock(clock), .reset_p(reset_p), .gpio_in(gpio_in), .gpio_out(gpio_out),
      .start(start), .halt_req(halt_req), .step(step), .prog_we(prog_we),
      .prog_addr(prog_addr), .prog_data(prog_data), .halted(halted), .pc(pc),
      .cf(cf), .retire(retire)
   );

   param_tiny_processor #(.DW(8), .AW(6)) dut8 (
      .clock(clock), .reset_p(reset_p), .gpio_in(b_gpio_in), .gpio_out(b_gpio_out),
      .start(b_start), .halt_req(b_halt_req), .step(b_step), .prog_we(b_prog_we),
      .prog_addr(b_prog_addr), .prog_data(b_prog_data), .halted(b_halted), .pc(b_pc),
      .cf(b_cf), .retire(b_retire)
   );

   typedef struct {
      logic [31:0] prog;   // word0 in bits [31:24]
      logic [3:0]  gin;
      int          steps;
      logic [3:0]  e_out;
      logic [3:0]  e_pc;
      logic        e_cf;
   } vec_t;

   localparam int NV = 13;
   vec_t vecs [NV];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      reset_p = 1'b1;
      @(negedge clock);
      reset_p = 1'b0;
      @(negedge clock);
   endtask

   task automatic wr4(input logic [3:0] a, input logic [7:0] w);
      prog_we = 1'b1; prog_addr = a; prog_data = w;
      @(negedge clock);
      prog_we = 1'b0;
   endtask

   task automatic wr8(input logic [5:0] a, input logic [11:0] w);
      b_prog_we = 1'b1; b_prog_addr = a; b_prog_data = w;
      @(negedge clock);
      b_prog_we = 1'b0;
   endtask

   task automatic step4();
      int c;
      step = 1'b1;
      @(negedge clock);
      step = 1'b0;
      c = 0;
      while (!retire && c < 20) begin
         @(negedge clock);
         c++;
      end
      chk("step4_retire", 32'(retire), 32'd1);
   endtask

   task automatic step8();
      int c;
      b_step = 1'b1;
      @(negedge clock);
      b_step = 1'b0;
      c = 0;
      while (!b_retire && c < 20) begin
         @(negedge clock);
         c++;
      end
      chk("step8_retire", 32'(b_retire), 32'd1);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic run_until_halted(input int budget, output int nret);
      int c;
      nret = 0;
      c = 0;
      while (c < budget) begin
         @(negedge clock);
         c++;
         if (retire) nret++;
         if (halted) break;
      end
      chk("halt_reached", 32'(halted), 32'd1);
   endtask

   task automatic request_halt();
      int n;
      halt_req = 1'b1;
      @(negedge clock);
      halt_req = 1'b0;
      run_until_halted(20, n);
   endtask

   initial begin
      int n, c, ncf, nchg, last_cyc;
      logic cf_prev;
      logic [3:0] prev_out;
      logic [3:0] chg_val [7];
      int chg_cyc [7];
      logic [7:0] pat [7];
      int gaps [6];

      reset_p = 1'b1; gpio_in = '0; start = 1'b0; halt_req = 1'b0; step = 1'b0;
      prog_we = 1'b0; prog_addr = '0; prog_data = '0;
      b_gpio_in = '0; b_start = 1'b0; b_halt_req = 1'b0; b_step = 1'b0;
      b_prog_we = 1'b0; b_prog_addr = '0; b_prog_data = '0;

      vecs[0]  = '{32'h053092C0, 4'h0, 3, 4'h7, 4'd3, 1'b0};
      vecs[1]  = '{32'h195990C0, 4'h0, 2, 4'h0, 4'd2, 1'b1};
      vecs[2]  = '{32'h195990C0, 4'h0, 3, 4'h2, 4'd3, 1'b0};
      vecs[3]  = '{32'h603095C0, 4'hC, 3, 4'h1, 4'd3, 1'b1};
      vecs[4]  = '{32'h7390C0C0, 4'h6, 2, 4'h9, 4'd2, 1'b0};
      vecs[5]  = '{32'h1721309F, 4'h0, 4, 4'h7, 4'd4, 1'b1};
      vecs[6]  = '{32'hA3C0C0C0, 4'h0, 1, 4'h0, 4'd3, 1'b0};
      vecs[7]  = '{32'h0F41B0C0, 4'h0, 3, 4'h0, 4'd3, 1'b0};
      vecs[8]  = '{32'h01B3C0C0, 4'h0, 2, 4'h0, 4'd3, 1'b0};
      vecs[9]  = '{32'h0F41D5C0, 4'h0, 3, 4'h0, 4'd3, 1'b0};
      vecs[10] = '{32'h8AC0C0C0, 4'h0, 1, 4'hA, 4'd1, 1'b0};
      vecs[11] = '{32'hF0C0C0C0, 4'h0, 1, 4'h0, 4'd1, 1'b0};
      vecs[12] = '{32'h0F41A0C0, 4'h0, 3, 4'h0, 4'd0, 1'b0};

      @(negedge clock);
      chk("rst_gpio", 32'(gpio_out), 32'd0);
      chk("rst_pc", 32'(pc), 32'd0);
      chk("rst_cf", 32'(cf), 32'd0);
      chk("rst_halted", 32'(halted), 32'd1);
      chk("rst_retire", 32'(retire), 32'd0);
      reset_p = 1'b0;
      @(negedge clock);

      // Table: each row is a 4-word program executed by single steps from reset.
      for (int i = 0; i < NV; i++) begin
         do_reset();
         for (int w = 0; w < 4; w++) wr4(4'(w), vecs[i].prog[31-8*w -: 8]);
         gpio_in = vecs[i].gin;
         for (int s = 0; s < vecs[i].steps; s++) step4();
         chk($sformatf("v%0d_gpio", i), 32'(gpio_out), 32'(vecs[i].e_out));
         chk($sformatf("v%0d_pc", i), 32'(pc), 32'(vecs[i].e_pc));
         chk($sformatf("v%0d_cf", i), 32'(cf), 32'(vecs[i].e_cf));
         chk($sformatf("v%0d_halted", i), 32'(halted), 32'd1);
      end
      gpio_in = '0;

      // Walking-bit output pattern in run mode.
      pat[0] = 8'h81; pat[1] = 8'h82; pat[2] = 8'h84; pat[3] = 8'h88;
      pat[4] = 8'h84; pat[5] = 8'h82; pat[6] = 8'hA0;
      gaps[0] = 5; gaps[1] = 5; gaps[2] = 5; gaps[3] = 5; gaps[4] = 5; gaps[5] = 10;
      do_reset();
      for (int w = 0; w < 7; w++) wr4(4'(w), pat[w]);
      pulse_start();
      chk("run_halted_low", 32'(halted), 32'd0);
      prev_out = gpio_out;
      nchg = 0;
      c = 0;
      while (nchg < 7 && c < 100) begin
         @(negedge clock);
         c++;
         if (gpio_out != prev_out) begin
            chg_val[nchg] = gpio_out;
            chg_cyc[nchg] = c;
            nchg++;
            prev_out = gpio_out;
         end
      end
      chk("pat_changes", 32'(nchg), 32'd7);
      for (int k = 0; k < nchg; k++) begin
         chk($sformatf("pat_val%0d", k), 32'(chg_val[k]), 32'(pat[k % 6][3:0] == 4'h0 ? 4'h1 : (k == 6 ? 4'h1 : pat[k][3:0])));
      end
      for (int k = 1; k < nchg; k++) begin
         chk($sformatf("pat_gap%0d", k), 32'(chg_cyc[k] - chg_cyc[k-1]), 32'(gaps[k-1]));
      end

      // Asynchronous reset mid-run, then re-run the retained program.
      c = 0;
      while (gpio_out != 4'h8 && c < 100) begin
         @(negedge clock);
         c++;
      end
      chk("mid_run_seen8", 32'(gpio_out), 32'h8);
      reset_p = 1'b1;
      #1;
      chk("arst_gpio", 32'(gpio_out), 32'd0);
      chk("arst_halted", 32'(halted), 32'd1);
      chk("arst_pc", 32'(pc), 32'd0);
      chk("arst_cf", 32'(cf), 32'd0);
      chk("arst_retire", 32'(retire), 32'd0);
      @(negedge clock);
      reset_p = 1'b0;
      @(negedge clock);
      pulse_start();
      c = 0;
      while (gpio_out == 4'h0 && c < 30) begin
         @(negedge clock);
         c++;
      end
      chk("rerun_first_out", 32'(gpio_out), 32'h1);
      request_halt();

      // ADD A,1 / JNC 0 counting loop, NOPs beyond.
      do_reset();
      wr4(4'd0, 8'h41);
      wr4(4'd1, 8'hB0);
      for (int w = 2; w < 16; w++) wr4(4'(w), 8'hC0);
      pulse_start();
      n = 0; ncf = 0; cf_prev = 1'b0; c = 0;
      while (c < 400) begin
         @(negedge clock);
         c++;
         if (retire) n++;
         if (cf && !cf_prev) ncf++;
         cf_prev = cf;
         if (pc == 4'd2) break;
      end
      chk("loop_pc2", 32'(pc), 32'd2);
      chk("loop_retires", 32'(n), 32'd32);
      chk("loop_cf_rises", 32'(ncf), 32'd1);
      repeat (12) @(negedge clock);
      chk("loop_nop_running", 32'(halted), 32'd0);
      request_halt();

      // HLT retires into HALT with pc past it; step then runs one instruction.
      do_reset();
      wr4(4'd0, 8'h11);
      wr4(4'd1, 8'hF0);
      wr4(4'd2, 8'h95);
      pulse_start();
      run_until_halted(40, n);
      chk("hlt_pc", 32'(pc), 32'd2);
      chk("hlt_retires", 32'(n), 32'd2);
      chk("hlt_gpio", 32'(gpio_out), 32'd0);
      step4();
      chk("hlt_step_gpio", 32'(gpio_out), 32'h6);
      chk("hlt_step_pc", 32'(pc), 32'd3);
      chk("hlt_step_halted", 32'(halted), 32'd1);

      // Write with start is honoured; write while running is dropped.
      do_reset();
      for (int w = 0; w < 3; w++) wr4(4'(w), 8'hC0);
      wr4(4'd3, 8'h87);
      wr4(4'd4, 8'hC0);
      start = 1'b1; prog_we = 1'b1; prog_addr = 4'd4; prog_data = 8'hF0;
      @(negedge clock);
      start = 1'b0; prog_we = 1'b0;
      wr4(4'd3, 8'h8E);
      run_until_halted(100, n);
      chk("we_run_gpio", 32'(gpio_out), 32'h7);
      chk("we_run_pc", 32'(pc), 32'd5);
      chk("we_run_retires", 32'(n), 32'd5);

      // halt_req with start in HALT keeps it halted; halt_req during EXEC of an ADD.
      do_reset();
      wr4(4'd0, 8'h43);
      wr4(4'd1, 8'h30);
      wr4(4'd2, 8'h92);
      start = 1'b1; halt_req = 1'b1;
      @(negedge clock);
      start = 1'b0; halt_req = 1'b0;
      chk("start_cancel_halted", 32'(halted), 32'd1);
      pulse_start();
      @(negedge clock);
      @(negedge clock);
      @(negedge clock);
      halt_req = 1'b1;
      @(negedge clock);
      halt_req = 1'b0;
      chk("hreq_wb_halted", 32'(halted), 32'd0);
      @(negedge clock);
      chk("hreq_halted", 32'(halted), 32'd1);
      chk("hreq_pc", 32'(pc), 32'd1);
      chk("hreq_retire", 32'(retire), 32'd1);
      step4();
      step4();
      chk("hreq_rega_out", 32'(gpio_out), 32'h5);
      chk("hreq_pc3", 32'(pc), 32'd3);

      // Wide instance: JMP to top address, pc wrap, 8-bit carry.
      do_reset();
      wr8(6'd0, 12'hA3F);
      wr8(6'h3F, 12'h0FF);
      step8();
      chk("w8_jmp_pc", 32'(b_pc), 32'h3F);
      step8();
      chk("w8_wrap_pc", 32'(b_pc), 32'h0);
      chk("w8_wrap_cf", 32'(b_cf), 32'd0);
      wr8(6'd0, 12'h401);
      wr8(6'd1, 12'h300);
      wr8(6'd2, 12'h905);
      step8();
      chk("w8_add_cf", 32'(b_cf), 32'd1);
      chk("w8_add_pc", 32'(b_pc), 32'd1);
      chk("w8_add_gpio", 32'(b_gpio_out), 32'h0);
      step8();
      step8();
      chk("w8_out", 32'(b_gpio_out), 32'h05);
      chk("w8_out_cf", 32'(b_cf), 32'd0);
      chk("w8_halted", 32'(b_halted), 32'd1);

      last_cyc = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks + last_cyc, failures);
      $finish;
   end

endmodule
